// File: rtl/fib_pair_serializer.sv
// fib_pair_serializer
//   Buffers (num, num2) word pairs in a small FIFO and emits them one word at a
//   time, older term first. It tracks the last two transferred words to flag a
//   downward step (out_wrap) and any break in the x[n] = x[n-1] + x[n-2]
//   recurrence (out_err, sticky).
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst        : asynchronous reset, active low
//   clear      : synchronous flush, active high (overrides push and transfer)
//   in_valid   : upstream pair present
//   in_ready   : a pair can be accepted this cycle (state-derived only)
//   in_num     : first (older) term of the pair
//   in_num2    : second (newer) term of the pair
//   out_valid  : out_data holds a word (FIFO not empty)
//   out_ready  : consumer accepts out_data
//   out_data   : current serialized word
//   out_index  : number of words transferred before this one, mod 256
//   out_wrap   : out_data is below the previously transferred word (unsigned)
//   out_err    : sticky recurrence-violation flag
module fib_pair_serializer #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_num,
  input  logic [W-1:0] in_num2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [7:0]   out_index,
  output logic         out_wrap,
  output logic         out_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_num  [DEPTH];
  logic [W-1:0]  mem_num2 [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          half_reg;
  logic [7:0]    index_reg;
  logic [W-1:0]  p1_reg;
  logic [W-1:0]  p2_reg;
  logic          p1_valid_reg;
  logic          p2_valid_reg;
  logic          err_reg;
  // Low while in reset and until the first edge after release, so in_ready
  // stays low across reset and rises from that first edge.
  logic          live_reg;

  logic          push;
  logic          xfer;
  logic          pop;
  logic [W-1:0]  recur_sum;

  assign in_ready  = live_reg && (count_reg < CW'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign out_data  = half_reg ? mem_num2[rd_ptr_reg] : mem_num[rd_ptr_reg];
  assign out_index = index_reg;
  assign out_err   = err_reg;
  assign out_wrap  = p1_valid_reg && (out_data < p1_reg);

  assign push      = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign pop       = xfer && half_reg;
  assign recur_sum = p1_reg + p2_reg;

  // Pair storage carries no reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      mem_num[wr_ptr_reg]  <= in_num;
      mem_num2[wr_ptr_reg] <= in_num2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      half_reg     <= 1'b0;
      index_reg    <= 8'd0;
      p1_reg       <= '0;
      p2_reg       <= '0;
      p1_valid_reg <= 1'b0;
      p2_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
      live_reg     <= 1'b0;
    end else begin
      live_reg <= 1'b1;
      if (clear) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        count_reg    <= '0;
        half_reg     <= 1'b0;
        index_reg    <= 8'd0;
        p1_valid_reg <= 1'b0;
        p2_valid_reg <= 1'b0;
        err_reg      <= 1'b0;
      end else begin
        // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
        if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);

        if (xfer) begin
          half_reg     <= ~half_reg;
          index_reg    <= index_reg + 8'd1;
          p1_reg       <= out_data;
          p1_valid_reg <= 1'b1;
          p2_reg       <= p1_reg;
          p2_valid_reg <= p1_valid_reg;
          if (p1_valid_reg && p2_valid_reg && (out_data != recur_sum))
            err_reg <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fib_pair_serializer.sv
module tb_fib_pair_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] in_num = '0;
  logic [15:0] in_num2 = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [7:0]  out_index;
  logic        out_wrap;
  logic        out_err;

  int tests_run = 0;
  int tests_failed = 0;

  fib_pair_serializer #(.W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_num2(in_num2),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_wrap(out_wrap), .out_err(out_err)
  );

  initial forever #5 clk = ~clk;

  task automatic do_clear();
    @(negedge clk); clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); clear = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    tests_run++; if (out_index !== 8'd0) begin tests_failed++; $display("FAIL reset_out_index got=%0d exp=0", out_index); end
    tests_run++; if (out_err !== 1'b0) begin tests_failed++; $display("FAIL reset_out_err got=%b exp=0", out_err); end
    tests_run++; if (out_wrap !== 1'b0) begin tests_failed++; $display("FAIL reset_out_wrap got=%b exp=0", out_wrap); end
    @(negedge clk); rst = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_pre_edge got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_post_edge got=%b exp=1", in_ready); end
    $display("[TB] reset: done");
  endtask

  task automatic test_basic();
    logic [15:0] a[5] = '{16'd1, 16'd2, 16'd5, 16'd13, 16'd34};
    logic [15:0] b[5] = '{16'd1, 16'd3, 16'd8, 16'd21, 16'd55};
    logic [15:0] e[10] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13, 16'd21, 16'd34, 16'd55};
    int pi = 0, wi = 0, cyc = 0;
    logic pushed, xfer;
    do_clear();
    while (wi < 10 && cyc < 100) begin
      @(negedge clk);
      in_valid = (pi < 5); in_num = (pi < 5) ? a[pi] : 16'd0; in_num2 = (pi < 5) ? b[pi] : 16'd0; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        tests_run++; if (out_data !== e[wi]) begin tests_failed++; $display("FAIL basic_data w=%0d got=%0d exp=%0d", wi, out_data, e[wi]); end
        tests_run++; if (out_index !== 8'(wi)) begin tests_failed++; $display("FAIL basic_index w=%0d got=%0d exp=%0d", wi, out_index, wi); end
        tests_run++; if (out_err !== 1'b0) begin tests_failed++; $display("FAIL basic_err w=%0d got=%b exp=0", wi, out_err); end
        tests_run++; if (out_wrap !== 1'b0) begin tests_failed++; $display("FAIL basic_wrap w=%0d got=%b exp=0", wi, out_wrap); end
        $display("[TB] basic: word %0d data=%0d idx=%0d", wi, out_data, out_index);
      end
      pushed = in_valid && in_ready; xfer = out_valid && out_ready;
      @(posedge clk);
      if (pushed) pi++;
      if (xfer) wi++;
      cyc++;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    tests_run++; if (wi != 10) begin tests_failed++; $display("FAIL basic_timeout words=%0d exp=10", wi); end
  endtask

  task automatic test_backpressure();
    logic [15:0] e[8] = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
    int wi = 0, cyc = 0;
    logic xfer;
    do_clear();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); in_valid = 1'b1; in_num = e[2*i]; in_num2 = e[2*i+1]; out_ready = 1'b0;
      #1;
      tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_fill_ready i=%0d got=%b exp=1", i, in_ready); end
      $display("[TB] backpressure: push pair %0d", i);
    end
    @(negedge clk); in_valid = 1'b1; in_num = 16'd90; in_num2 = 16'd100;
    #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
    @(negedge clk); #1;
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_full_hold got=%b exp=0", in_ready); end
    in_valid = 1'b0;
    while (wi < 8 && cyc < 40) begin
      @(negedge clk); out_ready = 1'b1;
      #1;
      if (out_valid) begin
        tests_run++; if (out_data !== e[wi]) begin tests_failed++; $display("FAIL bp_data w=%0d got=%0d exp=%0d", wi, out_data, e[wi]); end
        tests_run++; if (out_index !== 8'(wi)) begin tests_failed++; $display("FAIL bp_index w=%0d got=%0d exp=%0d", wi, out_index, wi); end
        tests_run++; if (in_ready !== (wi >= 2)) begin tests_failed++; $display("FAIL bp_ready w=%0d got=%b exp=%b", wi, in_ready, (wi >= 2)); end
        $display("[TB] backpressure: word %0d data=%0d", wi, out_data);
      end
      xfer = out_valid && out_ready;
      @(posedge clk);
      if (xfer) wi++;
      cyc++;
    end
    tests_run++; if (wi != 8) begin tests_failed++; $display("FAIL bp_timeout words=%0d exp=8", wi); end
    @(negedge clk); out_ready = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_fifth_dropped got=%b exp=0", out_valid); end
  endtask

  task automatic test_wrap();
    logic [15:0] f[26];
    int pi = 0, wi = 0, cyc = 0;
    logic pushed, xfer, exp_wrap;
    f[0] = 16'd1; f[1] = 16'd1;
    for (int i = 2; i < 26; i++) f[i] = f[i-1] + f[i-2];
    do_clear();
    while (wi < 26 && cyc < 200) begin
      @(negedge clk);
      in_valid = (pi < 13); in_num = (pi < 13) ? f[2*pi] : 16'd0; in_num2 = (pi < 13) ? f[2*pi+1] : 16'd0; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        exp_wrap = (wi > 0) ? (f[wi] < f[wi-1]) : 1'b0;
        tests_run++; if (out_data !== f[wi]) begin tests_failed++; $display("FAIL wrap_data w=%0d got=%0d exp=%0d", wi, out_data, f[wi]); end
        tests_run++; if (out_index !== 8'(wi)) begin tests_failed++; $display("FAIL wrap_index w=%0d got=%0d exp=%0d", wi, out_index, wi); end
        tests_run++; if (out_wrap !== exp_wrap) begin tests_failed++; $display("FAIL wrap_flag w=%0d got=%b exp=%b", wi, out_wrap, exp_wrap); end
        tests_run++; if (out_err !== 1'b0) begin tests_failed++; $display("FAIL wrap_err w=%0d got=%b exp=0", wi, out_err); end
        if (wi == 23) begin
          tests_run++; if (out_data !== 16'd46368) begin tests_failed++; $display("FAIL wrap_idx23 got=%0d exp=46368", out_data); end
        end
        if (wi == 24) begin
          tests_run++; if (out_data !== 16'd9489 || out_wrap !== 1'b1) begin tests_failed++; $display("FAIL wrap_idx24 got=%0d/%b exp=9489/1", out_data, out_wrap); end
        end
        $display("[TB] wrap: word %0d data=%0d wrap=%b", wi, out_data, out_wrap);
      end
      pushed = in_valid && in_ready; xfer = out_valid && out_ready;
      @(posedge clk);
      if (pushed) pi++;
      if (xfer) wi++;
      cyc++;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    tests_run++; if (wi != 26) begin tests_failed++; $display("FAIL wrap_timeout words=%0d exp=26", wi); end
  endtask

  task automatic test_index_wrap();
    int pi = 0, wi = 0, cyc = 0;
    logic pushed, xfer;
    do_clear();
    in_num = 16'd0; in_num2 = 16'd0;
    while (wi < 260 && cyc < 700) begin
      @(negedge clk);
      in_valid = (pi < 130); out_ready = 1'b1;
      #1;
      if (out_valid) begin
        tests_run++; if (out_index !== 8'(wi)) begin tests_failed++; $display("FAIL idxwrap_index w=%0d got=%0d exp=%0d", wi, out_index, 8'(wi)); end
        if (wi >= 254 && wi <= 257) $display("[TB] index_wrap: word %0d idx=%0d", wi, out_index);
      end
      pushed = in_valid && in_ready; xfer = out_valid && out_ready;
      @(posedge clk);
      if (pushed) pi++;
      if (xfer) wi++;
      cyc++;
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    tests_run++; if (wi != 260) begin tests_failed++; $display("FAIL idxwrap_timeout words=%0d exp=260", wi); end
  endtask

  task automatic test_error();
    logic [15:0] a[3] = '{16'd1, 16'd2, 16'd6};
    logic [15:0] b[3] = '{16'd1, 16'd4, 16'd10};
    logic [15:0] e[6] = '{16'd1, 16'd1, 16'd2, 16'd4, 16'd6, 16'd10};
    int pi = 0, wi = 0, cyc = 0;
    logic pushed, xfer;
    do_clear();
    while (wi < 6 && cyc < 60) begin
      @(negedge clk);
      in_valid = (pi < 3); in_num = (pi < 3) ? a[pi] : 16'd0; in_num2 = (pi < 3) ? b[pi] : 16'd0; out_ready = 1'b1;
      #1;
      if (out_valid) begin
        tests_run++; if (out_data !== e[wi]) begin tests_failed++; $display("FAIL err_data w=%0d got=%0d exp=%0d", wi, out_data, e[wi]); end
        tests_run++; if (out_err !== (wi >= 4)) begin tests_failed++; $display("FAIL err_flag w=%0d got=%b exp=%b", wi, out_err, (wi >= 4)); end
        $display("[TB] error: word %0d data=%0d err=%b", wi, out_data, out_err);
      end
      pushed = in_valid && in_ready; xfer = out_valid && out_ready;
      @(posedge clk);
      if (pushed) pi++;
      if (xfer) wi++;
      cyc++;
    end
    tests_run++; if (wi != 6) begin tests_failed++; $display("FAIL err_timeout words=%0d exp=6", wi); end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b0;
    #1;
    tests_run++; if (out_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky got=%b exp=1", out_err); end
    do_clear();
    #1;
    tests_run++; if (out_err !== 1'b0) begin tests_failed++; $display("FAIL err_cleared got=%b exp=0", out_err); end
    tests_run++; if (out_index !== 8'd0) begin tests_failed++; $display("FAIL err_clear_index got=%0d exp=0", out_index); end
  endtask

  task automatic test_simultaneous();
    do_clear();
    @(negedge clk); in_valid = 1'b1; in_num = 16'd100; in_num2 = 16'd200; out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    #1;
    tests_run++; if (out_data !== 16'd100) begin tests_failed++; $display("FAIL simul_first got=%0d exp=100", out_data); end
    @(negedge clk); in_valid = 1'b1; in_num = 16'd300; in_num2 = 16'd500; out_ready = 1'b1;
    #1;
    tests_run++; if (out_data !== 16'd200 || in_ready !== 1'b1) begin tests_failed++; $display("FAIL simul_half got=%0d/%b exp=200/1", out_data, in_ready); end
    @(negedge clk); in_valid = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b1 || out_data !== 16'd300) begin tests_failed++; $display("FAIL simul_new_head got=%b/%0d exp=1/300", out_valid, out_data); end
    tests_run++; if (out_index !== 8'd2) begin tests_failed++; $display("FAIL simul_index got=%0d exp=2", out_index); end
    @(negedge clk); #1;
    tests_run++; if (out_data !== 16'd500) begin tests_failed++; $display("FAIL simul_second got=%0d exp=500", out_data); end
    @(negedge clk); out_ready = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL simul_count got=%b exp=0", out_valid); end
    $display("[TB] simultaneous: done");
  endtask

  task automatic test_reset_mid();
    do_clear();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_num = 16'(7 + i); in_num2 = 16'(9 + i); out_ready = 1'b0;
    end
    @(negedge clk); in_valid = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_queued got=%b exp=1", out_valid); end
    #2 rst = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin tests_failed++; $display("FAIL rmid_async got=%b/%b exp=0/0", out_valid, in_ready); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); in_valid = 1'b1; in_num = 16'd1; in_num2 = 16'd1; out_ready = 1'b1;
    #1;
    tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rmid_ready got=%b exp=1", in_ready); end
    @(negedge clk); in_valid = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b1 || out_data !== 16'd1 || out_index !== 8'd0 || out_err !== 1'b0) begin
      tests_failed++; $display("FAIL rmid_first got=%b/%0d/%0d/%b exp=1/1/0/0", out_valid, out_data, out_index, out_err);
    end
    @(negedge clk); #1;
    tests_run++; if (out_data !== 16'd1 || out_index !== 8'd1) begin tests_failed++; $display("FAIL rmid_second got=%0d/%0d exp=1/1", out_data, out_index); end
    @(negedge clk); out_ready = 1'b0;
    #1;
    tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_stale got=%b exp=0", out_valid); end
    $display("[TB] reset_mid: done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_index_wrap();
    test_error();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fib_pair_serializer.md
FIB_PAIR_SERIALIZER -- requirements
Module: fib_pair_serializer

Interface
REQ-001 SHALL have parameter W, default 16: data word width.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO capacity in word pairs (power of two, ≥2).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port clear, input, 1: synchronous flush, active-high.
REQ-006 SHALL have port in_valid, input, 1: an upstream pair is present.
REQ-007 SHALL have port in_ready, output, 1: a pair can be accepted this cycle.
REQ-008 SHALL have port in_num, input, W: first (older) term of the pair.
REQ-009 SHALL have port in_num2, input, W: second (newer) term of the pair.
REQ-010 SHALL have port out_valid, output, 1: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1: the consumer accepts out_data.
REQ-012 SHALL have port out_data, output, W: current serialized term.
REQ-013 SHALL have port out_index, output, 8: count of words transferred before the current one, mod 256.
REQ-014 SHALL have port out_wrap, output, 1: out_data < the previously transferred word (unsigned).
REQ-015 SHALL have port out_err, output, 1: sticky recurrence-violation flag.

Function
REQ-016 SHALL accept a pair when in_valid && in_ready; in_ready = (pair count < DEPTH), registered or derived only from state, with no combinational path from out_ready.
REQ-017 SHALL present a pair pushed into an empty FIFO at edge t on out_valid/out_data after edge t (one-cycle latency).
REQ-018 SHALL set out_valid = (pair count != 0).
REQ-019 SHALL drive out_data = head.num while half==0 and head.num2 while half==1.
REQ-020 SHALL, on transfer (out_valid && out_ready) with half==0, set half to 1 with no pop.
REQ-021 SHALL, on transfer with half==1, set half to 0 and pop the head pair.
REQ-022 SHALL handle a push and a pop in the same cycle with the count unchanged and no data loss; when full, no push occurs (in_ready=0).
REQ-023 SHALL wrap read and write pointers modulo DEPTH.
REQ-024 SHALL increment out_index by 1 per transferred word, wrapping 255→0.
REQ-025 SHALL hold the last two transferred words (p1 = newest, p2 = older), each with its own valid bit.
REQ-026 SHALL assert out_wrap combinationally when p1 is valid and out_data < p1; otherwise 0.
REQ-027 SHALL set out_err on a transfer when p1 and p2 are both valid and out_data != (p1 + p2) mod 2^W; once set, out_err remains 1 until reset or clear.
REQ-028 SHALL, while clear=1, empty the FIFO and zero half, out_index, p1/p2 valid bits and out_err; clear overrides a simultaneous push or transfer.
REQ-029 SHALL leave out_data contents unconstrained while out_valid=0.

Reset
REQ-030 SHALL, on rst low (asynchronous), immediately force count=0, half=0, out_valid=0, in_ready=0, out_index=0, out_wrap=0, out_err=0, and clear p1/p2 valid bits.
REQ-031 SHALL drive in_ready=1 from the first clock edge after rst deasserts, with no prior FIFO contents surviving.
REQ-032 SHALL discard in-flight pairs and the partially consumed half on a mid-operation reset.

Verification
REQ-033 Basic: push (1,1),(2,3),(5,8),(13,21),(34,55) with out_ready=1 -> out_data 1,1,2,3,5,8,13,21,34,55; out_index 0..9; out_err=0; out_wrap=0.
REQ-034 Backpressure: out_ready=0 and push 4 pairs -> in_ready=0 after the 4th push; 5th pair not accepted; then out_ready=1 -> 8 words in order, in_ready returns to 1 after the first pop.
REQ-035 Wrap: stream the Fibonacci sequence from (1,1) -> idx23=46368, idx24=9489 with out_wrap=1; out_err stays 0.
REQ-036 Error: push (1,1),(2,4) -> out_err rises on the transfer of word 4 (idx3) and stays 1 through later valid terms until clear.
REQ-037 Simultaneous: FIFO holds 1 pair with half=1; same cycle push and transfer -> count stays 1, next out_data = new pair's num.
REQ-038 Reset mid-stream: assert rst low between clock edges with 3 pairs queued -> out_valid=0 at once; after release, pushing (1,1) yields out_index 0, out_err 0.
